gaussian_blur_3x3: RTL



---
 rtl/gaussian_blur_3x3.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/gaussian_blur_3x3.sv
// 3x3 Gaussian blur (1 2 1 / 2 4 2 / 1 2 1, /16) between two SRAMs, edge
// replication at borders; Go/Done handshake, Done held until next Go.
// Ports: Clk, Rst (sync, active-high), Go; input SRAM I_Addr/I_Data/I_RW/I_En;
// output SRAM O_Addr/O_Data/O_RW/O_En; Done.
// Option: define GAUSS_ROUND_EN for round-half-up instead of truncation.
module gaussian_blur_3x3 #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int A_WIDTH = 17,
  parameter int D_WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Go,
  output logic [A_WIDTH-1:0] I_Addr,
  input  logic [D_WIDTH-1:0] I_Data,
  output logic               I_RW,
  output logic               I_En,
  output logic [A_WIDTH-1:0] O_Addr,
  output logic [D_WIDTH-1:0] O_Data,
  output logic               O_RW,
  output logic               O_En,
  output logic               Done
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int SW = D_WIDTH + 4;
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
  localparam logic [A_WIDTH-1:0] WSTEP = A_WIDTH'(WIDTH);

  typedef enum logic [3:0] {
    S_IDLE, S_P0, S_P1, S_P2, S_P3,
    S_F0, S_F1, S_F2, S_F3, S_WRITE, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [A_WIDTH-1:0] rowbase;
  logic [D_WIDTH-1:0] top, mid;
  // index 0 = row above, 1 = current row, 2 = row below
  logic [D_WIDTH-1:0] wl [3];
  logic [D_WIDTH-1:0] wc [3];
  logic [D_WIDTH-1:0] wr [3];

  logic [XW-1:0]      xn;
  logic [A_WIDTH-1:0] rb_up, rb_dn, col;
  logic [SW-1:0]      sum;
  logic [D_WIDTH-1:0] pix;

  assign I_RW = 1'b0;

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (Go) state_nx = S_P0;
      S_P0:    state_nx = S_P1;
      S_P1:    state_nx = S_P2;
      S_P2:    state_nx = S_P3;
      S_P3:    state_nx = S_F0;
      S_F0:    state_nx = S_F1;
      S_F1:    state_nx = S_F2;
      S_F2:    state_nx = S_F3;
      S_F3:    state_nx = S_WRITE;
      S_WRITE: begin
        if (x != XMAX)      state_nx = S_F0;
        else if (y != YMAX) state_nx = S_P0;
        else                state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Clamped neighbour rows/column; row bases derived by +/- WIDTH
  always_comb begin
    xn    = (x == XMAX) ? x : x + XW'(1);
    col   = A_WIDTH'(xn);
    rb_up = (y == '0)   ? rowbase : rowbase - WSTEP;
    rb_dn = (y == YMAX) ? rowbase : rowbase + WSTEP;
  end

  always_comb begin
    sum = SW'(wl[0]) + SW'(wl[2]) + SW'(wr[0]) + SW'(wr[2])
        + ((SW'(wl[1]) + SW'(wc[0]) + SW'(wc[2]) + SW'(wr[1])) << 1)
        + (SW'(wc[1]) << 2);
`ifdef GAUSS_ROUND_EN
    // max 4080+8 still fits in SW bits, so no saturation needed
    pix = D_WIDTH'((sum + SW'(8)) >> 4);
`else
    pix = D_WIDTH'(sum >> 4);
`endif
  end

  always_comb begin
    I_En   = 1'b0;
    I_Addr = '0;
    O_En   = 1'b0;
    O_RW   = 1'b0;
    O_Addr = '0;
    O_Data = '0;
    unique case (state)
      S_P0: begin I_En = 1'b1; I_Addr = rb_up;   end
      S_P1: begin I_En = 1'b1; I_Addr = rowbase; end
      S_P2: begin I_En = 1'b1; I_Addr = rb_dn;   end
      S_F0: begin I_En = 1'b1; I_Addr = rb_up + col;   end
      S_F1: begin I_En = 1'b1; I_Addr = rowbase + col; end
      S_F2: begin I_En = 1'b1; I_Addr = rb_dn + col;   end
      S_WRITE: begin
        O_En   = 1'b1;
        O_RW   = 1'b1;
        O_Addr = rowbase + A_WIDTH'(x);
        O_Data = pix;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      x       <= '0;
      y       <= '0;
      rowbase <= '0;
      top     <= '0;
      mid     <= '0;
      Done    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        wl[i] <= '0;
        wc[i] <= '0;
        wr[i] <= '0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Go) begin
            x       <= '0;
            y       <= '0;
            rowbase <= '0;
            Done    <= 1'b0;
          end
        end
        S_P1, S_F1: top <= I_Data;
        S_P2, S_F2: mid <= I_Data;
        S_P3: begin
          // row start: replicate column 0 as the left neighbour
          wl[0] <= top; wl[1] <= mid; wl[2] <= I_Data;
          wc[0] <= top; wc[1] <= mid; wc[2] <= I_Data;
        end
        S_F3: begin
          wr[0] <= top; wr[1] <= mid; wr[2] <= I_Data;
        end
        S_WRITE: begin
          for (int i = 0; i < 3; i++) begin
            wl[i] <= wc[i];
            wc[i] <= wr[i];
          end
          if (x != XMAX) begin
            x <= x + XW'(1);
          end else if (y != YMAX) begin
            x       <= '0;
            y       <= y + YW'(1);
            rowbase <= rowbase + WSTEP;
          end else begin
            Done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
